// File: rtl/onehot_strobe_driver.sv
// Binary-to-one-hot strobe driver: accepts a 4-bit code over valid/ready, drives
// the matching line of a 16-bit bus for HOLD_CYCLES, then idles GAP_CYCLES at zero.
module onehot_strobe_driver #(
   parameter int unsigned HOLD_CYCLES = 4,
   parameter int unsigned GAP_CYCLES  = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  B,
   input  logic        abort,
   output logic [15:0] H,
   output logic        busy,
   output logic        done
);

   localparam int unsigned CW = 8;
   localparam int unsigned HW = 16;
   localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      GAP   = 2'd2
   } state_t;

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic [3:0]    r_code;
   logic [HW-1:0] r_h;
   logic          r_busy;
   logic          r_done;
   logic          w_accept;

   assign in_ready = (r_state == IDLE) && !abort && !rst;
   assign w_accept = in_valid && in_ready;
   assign H        = r_h;
   assign busy     = r_busy;
   assign done     = r_done;

   // Single-process FSM; every output is a register so H is glitch-free.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_code  <= '0;
         r_h     <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               r_h    <= '0;
               r_busy <= 1'b0;
               if (w_accept) begin
                  r_code  <= B;
                  r_h     <= HW'(1) << B;
                  r_busy  <= 1'b1;
                  r_cnt   <= HOLD_LOAD;
                  r_state <= DRIVE;
               end
            end
            DRIVE: begin
               if (abort) begin
                  r_h     <= '0;
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end else if (r_cnt == '0) begin
                  r_h    <= '0;
                  r_done <= 1'b1;
                  if (GAP_CYCLES > 0) begin
                     r_cnt   <= GAP_LOAD;
                     r_state <= GAP;
                  end else begin
                     r_busy  <= 1'b0;
                     r_state <= IDLE;
                  end
               end else begin
                  r_h   <= HW'(1) << r_code;
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            GAP: begin
               r_h <= '0;
               if (abort || (r_cnt == '0)) begin
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            default: begin
               r_h     <= '0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule
